rosc_health_monitor: RTL

- Downstream consumer of the ring-oscillator measurement FSM.
- Captures each 16-bit ROSC count when the FSM flags it ready, then returns the one-cycle read-complete handshake.
- Maintains running statistics: last sample, EWMA, minimum, and sample count.
- Raises a debounced, hysteretic degradation flag when counts fall below a CPU-programmed threshold.

---
 rtl/rosc_pkg.sv | 21 ++
 rtl/rosc_stats_update.sv | 71 +++++++
 rtl/rosc_health_monitor.sv | 128 ++++++++++++
 3 files changed

// File: rtl/rosc_pkg.sv
// Shared types and constants for the ring-oscillator measurement path and its health monitor.
package rosc_pkg;

  localparam int unsigned ROSC_W = 16;

  typedef enum logic [1:0] {
    Idle    = 2'd0,
    Capture = 2'd1,
    Ack     = 2'd2,
    Gap     = 2'd3
  } monstate_t;

  // Mode encodings as seen by the upstream measurement FSM.
  typedef enum logic [1:0] {
    RoscModeOff        = 2'd0,
    RoscModeSingle     = 2'd1,
    RoscModeContinuous = 2'd2,
    RoscModeCalibrate  = 2'd3
  } rosc_mode_t;

endpackage

// File: rtl/rosc_stats_update.sv
// Combinational next-value computation for the ROSC running statistics and degradation flag.
module rosc_stats_update
  import rosc_pkg::*;
#(
  parameter int unsigned AVG_SHIFT = 2,
  parameter int unsigned DEBOUNCE  = 3,
  parameter int unsigned HYST      = 16
) (
  input  logic [ROSC_W-1:0] sample_i,
  input  logic [ROSC_W-1:0] avg_i,
  input  logic [ROSC_W-1:0] min_i,
  input  logic [ROSC_W-1:0] count_i,
  input  logic [ROSC_W-1:0] threshold_i,
  input  logic [3:0]        below_cnt_i,
  input  logic              degraded_i,
  output logic [ROSC_W-1:0] avg_o,
  output logic [ROSC_W-1:0] min_o,
  output logic [ROSC_W-1:0] count_o,
  output logic [3:0]        below_cnt_o,
  output logic              degraded_o
);

  logic               first;
  logic               below;
  logic signed [16:0] diff;
  logic signed [16:0] diff_sh;
  logic signed [17:0] sum;
  logic [16:0]        thr_hyst;
  logic [ROSC_W-1:0]  thr_sat;

  always_comb begin
    first   = (count_i == '0);
    diff    = $signed({1'b0, sample_i}) - $signed({1'b0, avg_i});
    diff_sh = diff >>> AVG_SHIFT;
    sum     = $signed({2'b00, avg_i}) + $signed({diff_sh[16], diff_sh});

    if (first) begin
      avg_o = sample_i;
    end else if (sum[17]) begin
      avg_o = '0;
    end else if (sum[16]) begin
      avg_o = '1;
    end else begin
      avg_o = sum[15:0];
    end

    min_o   = (first || (sample_i < min_i)) ? sample_i : min_i;
    count_o = (count_i == '1) ? count_i : count_i + 16'd1;

    // Clear level is Threshold+HYST, saturated so a max-scale threshold can still clear.
    thr_hyst = {1'b0, threshold_i} + 17'(HYST);
    thr_sat  = thr_hyst[16] ? '1 : thr_hyst[15:0];

    below = (sample_i < threshold_i);
    if (!below) begin
      below_cnt_o = 4'd0;
    end else if (below_cnt_i >= 4'(DEBOUNCE)) begin
      below_cnt_o = 4'(DEBOUNCE);
    end else begin
      below_cnt_o = below_cnt_i + 4'd1;
    end

    degraded_o = degraded_i;
    if (below && (below_cnt_o == 4'(DEBOUNCE))) begin
      degraded_o = 1'b1;
    end else if (sample_i >= thr_sat) begin
      degraded_o = 1'b0;
    end
  end

endmodule

// File: rtl/rosc_health_monitor.sv
// Captures ROSC counts from the measurement FSM, acknowledges them, and tracks health statistics.
module rosc_health_monitor
  import rosc_pkg::*;
#(
  parameter int unsigned AVG_SHIFT  = 2,
  parameter int unsigned DEBOUNCE   = 3,
  parameter int unsigned HYST       = 16,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic              Clk,
  input  logic              ResetN,
  input  logic              Enable,
  input  logic              ClearStats,
  input  logic [ROSC_W-1:0] ROSCReading,
  input  logic              ROSCValReady,
  input  logic [ROSC_W-1:0] Threshold,
  output logic              CPUReadComplete,
  output logic [ROSC_W-1:0] LastSample,
  output logic [ROSC_W-1:0] AvgValue,
  output logic [ROSC_W-1:0] MinValue,
  output logic [ROSC_W-1:0] SampleCount,
  output logic              NewSample,
  output logic              Degraded,
  output logic [1:0]        State
);

  monstate_t         state_q, state_d;
  logic [7:0]        gap_q, gap_d;
  logic [ROSC_W-1:0] last_q, avg_q, min_q, count_q;
  logic [3:0]        below_q;
  logic              degraded_q, new_sample_q, ack_q;

  logic [ROSC_W-1:0] avg_nxt, min_nxt, count_nxt;
  logic [3:0]        below_nxt;
  logic              degraded_nxt;

  rosc_stats_update #(
    .AVG_SHIFT (AVG_SHIFT),
    .DEBOUNCE  (DEBOUNCE),
    .HYST      (HYST)
  ) u_stats_update (
    .sample_i    (ROSCReading),
    .avg_i       (avg_q),
    .min_i       (min_q),
    .count_i     (count_q),
    .threshold_i (Threshold),
    .below_cnt_i (below_q),
    .degraded_i  (degraded_q),
    .avg_o       (avg_nxt),
    .min_o       (min_nxt),
    .count_o     (count_nxt),
    .below_cnt_o (below_nxt),
    .degraded_o  (degraded_nxt)
  );

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    if (!Enable) begin
      state_d = Idle;
      gap_d   = 8'd0;
    end else begin
      unique case (state_q)
        Idle:    if (ROSCValReady) state_d = Capture;
        Capture: state_d = Ack;
        Ack: begin
          state_d = Gap;
          gap_d   = 8'd0;
        end
        Gap: begin
          if (gap_q == 8'(GAP_CYCLES - 1)) begin
            state_d = Idle;
          end else begin
            gap_d = gap_q + 8'd1;
          end
        end
        default: state_d = Idle;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q      <= Idle;
      gap_q        <= 8'd0;
      last_q       <= '0;
      avg_q        <= '0;
      min_q        <= '0;
      count_q      <= '0;
      below_q      <= 4'd0;
      degraded_q   <= 1'b0;
      new_sample_q <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      new_sample_q <= 1'b0;
      ack_q        <= (state_q == Ack) && Enable;
      // A clear wins over a coincident capture; the handshake still completes.
      if (ClearStats) begin
        last_q     <= '0;
        avg_q      <= '0;
        min_q      <= '0;
        count_q    <= '0;
        below_q    <= 4'd0;
        degraded_q <= 1'b0;
      end else if (state_q == Capture) begin
        last_q       <= ROSCReading;
        avg_q        <= avg_nxt;
        min_q        <= min_nxt;
        count_q      <= count_nxt;
        below_q      <= below_nxt;
        degraded_q   <= degraded_nxt;
        new_sample_q <= 1'b1;
      end
    end
  end

  assign CPUReadComplete = ack_q;
  assign LastSample      = last_q;
  assign AvgValue        = avg_q;
  assign MinValue        = min_q;
  assign SampleCount     = count_q;
  assign NewSample       = new_sample_q;
  assign Degraded        = degraded_q;
  assign State           = state_q;

endmodule
